cfg_source_arbiter: RTL and testbench

- Shares the single eFPGA configuration byte-stream port between up to NUM_REQ bitstream sources: UART loader, USB DFU channel 1, SPI-flash boot reader.
- Grants one source at a time and locks it for a whole transfer.
- Registers the granted stream through a one-entry output buffer toward the config frame loader.
- Releases on end-of-transfer, request drop or inactivity timeout, then re-arbitrates round-robin.

---
 rtl/cfg_source_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_cfg_source_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_source_arbiter.sv
// Round-robin arbiter that locks one bitstream source onto the shared eFPGA
// config byte stream, with a one-entry output buffer and an idle timeout.
//
// Ports:
//   clk, reset             : system clock, async active-high reset
//   req_i                  : per-source transfer request (level)
//   data_i/valid_i/last_i  : per-source beat, valid and end-of-transfer
//   ready_o                : per-source beat accept (granted source only)
//   cfg_data_o/cfg_valid_o : buffered beat toward the config frame loader
//   cfg_ready_i            : config frame loader accept
//   grant_o                : one-hot current owner, zero when unowned
//   busy_o                 : owner locked or draining
//   timeout_o              : one-cycle pulse on forced release
module cfg_source_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int DATA_WIDTH   = 8,
  parameter int IDLE_TIMEOUT = 1200000,
  parameter int TMO_WIDTH    = 21
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
  input  logic [NUM_REQ-1:0]            valid_i,
  input  logic [NUM_REQ-1:0]            last_i,
  output logic [NUM_REQ-1:0]            ready_o,
  output logic [DATA_WIDTH-1:0]         cfg_data_o,
  output logic                          cfg_valid_o,
  input  logic                          cfg_ready_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  output logic                          timeout_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOCKED,
    S_DRAIN
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [TMO_WIDTH-1:0]   tmo_q, tmo_d;
  logic                   buf_valid_q, buf_valid_d;
  logic [DATA_WIDTH-1:0]  buf_data_q, buf_data_d;
  logic                   timeout_q, timeout_d;

  logic                   accept;
  logic [NUM_REQ-1:0]     ready;
  logic                   hs;
  logic                   hs_last;
  logic                   own_req;
  logic                   tmo_hit;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   win_found;
  logic [PTR_W-1:0]       win_idx;
  logic [PTR_W-1:0]       win_nxt;
  logic [NUM_REQ-1:0]     win_oh;

  // Buffer can take a beat when empty or being emptied this cycle.
  assign accept  = !buf_valid_q || cfg_ready_i;
  assign ready   = (state_q == S_LOCKED)
                 ? (grant_q & {NUM_REQ{accept}}) : '0;
  assign tmo_hit = (tmo_q == TMO_WIDTH'(IDLE_TIMEOUT - 1));

  // Owner view: grant is one-hot so OR-reduction selects it.
  always_comb begin
    sel_data = '0;
    hs       = 1'b0;
    hs_last  = 1'b0;
    own_req  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) begin
        sel_data = sel_data | data_i[k*DATA_WIDTH +: DATA_WIDTH];
        own_req  = own_req | req_i[k];
        hs       = hs | (valid_i[k] & ready[k]);
        hs_last  = hs_last | (valid_i[k] & ready[k] & last_i[k]);
      end
    end
  end

  // First requester at or above the pointer, wrapping.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] cand;
    idx       = 0;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = PTR_W'(idx);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_nxt = (win_idx == PTR_W'(NUM_REQ - 1))
            ? '0 : win_idx + 1'b1;
    win_oh  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      win_oh[k] = (win_idx == PTR_W'(k));
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    tmo_d       = tmo_q;
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    timeout_d   = 1'b0;

    // A load wins over a drain so the buffer sustains 1 beat/cycle.
    if (hs) begin
      buf_valid_d = 1'b1;
      buf_data_d  = sel_data;
    end else if (buf_valid_q && cfg_ready_i) begin
      buf_valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (win_found) begin
          grant_d = win_oh;
          ptr_d   = win_nxt;
          state_d = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (hs) begin
          tmo_d = '0;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + 1'b1;
        end
        priority case (1'b1)
          hs_last: begin
            state_d = S_DRAIN;
          end
          (!hs && !own_req): begin
            state_d = S_DRAIN;
          end
          (!hs && tmo_hit): begin
            state_d   = S_DRAIN;
            timeout_d = 1'b1;
          end
          default: begin
          end
        endcase
      end
      S_DRAIN: begin
        if (accept) begin
          grant_d = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      tmo_q       <= '0;
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      tmo_q       <= tmo_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      timeout_q   <= timeout_d;
    end
  end

  assign ready_o     = ready;
  assign cfg_data_o  = buf_data_q;
  assign cfg_valid_o = buf_valid_q;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q != S_IDLE);
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_cfg_source_arbiter.sv
// Scoreboard bench for cfg_source_arbiter (IDLE_TIMEOUT=16 build).
// Drivers queue expected beats/grants; a negedge monitor checks them.
module tb_cfg_source_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req_i;
  logic [23:0] data_i;
  logic [2:0]  valid_i;
  logic [2:0]  last_i;
  logic [2:0]  ready_o;
  logic [7:0]  cfg_data_o;
  logic        cfg_valid_o;
  logic        cfg_ready_i;
  logic [2:0]  grant_o;
  logic        busy_o;
  logic        timeout_o;

  int nvec  = 0;
  int nfail = 0;
  int tmo_cnt = 0;

  logic [7:0] exp_q[$];
  logic [2:0] gexp_q[$];
  logic [7:0] e_data;
  logic [2:0] e_grant;
  logic       stall_prev = 1'b0;
  logic [7:0] data_prev  = '0;
  logic [2:0] grant_prev = '0;
  logic       tmo_prev   = 1'b0;
  bit         bp_en      = 1'b0;

  cfg_source_arbiter #(
    .NUM_REQ      (3),
    .DATA_WIDTH   (8),
    .IDLE_TIMEOUT (16),
    .TMO_WIDTH    (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .last_i      (last_i),
    .ready_o     (ready_o),
    .cfg_data_o  (cfg_data_o),
    .cfg_valid_o (cfg_valid_o),
    .cfg_ready_i (cfg_ready_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: output beats, grants, stall behaviour, timeout pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (cfg_valid_o && cfg_ready_i) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nfail++;
          $display("FAIL cfg_data: unexpected beat %02h", cfg_data_o);
        end else begin
          e_data = exp_q.pop_front();
          if (cfg_data_o !== e_data) begin
            nfail++;
            $display("FAIL cfg_data: got %02h expected %02h",
                     cfg_data_o, e_data);
          end
        end
      end
      if (stall_prev) begin
        nvec++;
        if (!cfg_valid_o || cfg_data_o !== data_prev) begin
          nfail++;
          $display("FAIL stall_hold: got v=%0b d=%02h expected v=1 d=%02h",
                   cfg_valid_o, cfg_data_o, data_prev);
        end
      end
      if (cfg_valid_o && !cfg_ready_i) begin
        nvec++;
        if (ready_o !== 3'b000) begin
          nfail++;
          $display("FAIL ready_stall: got %03b expected 000", ready_o);
        end
      end
      if (cfg_valid_o) begin
        nvec++;
        if (grant_o === 3'b000) begin
          nfail++;
          $display("FAIL owner: got grant 000 with cfg_valid_o=1");
        end
      end
      if (grant_o !== grant_prev && grant_o !== 3'b000) begin
        nvec++;
        if (grant_prev !== 3'b000) begin
          nfail++;
          $display("FAIL grant_gap: got %03b directly after %03b",
                   grant_o, grant_prev);
        end else if (gexp_q.size() == 0) begin
          nfail++;
          $display("FAIL grant: got unexpected %03b", grant_o);
        end else begin
          e_grant = gexp_q.pop_front();
          if (grant_o !== e_grant) begin
            nfail++;
            $display("FAIL grant: got %03b expected %03b",
                     grant_o, e_grant);
          end
        end
      end
      if (timeout_o && !tmo_prev) tmo_cnt++;
      if (timeout_o && tmo_prev) begin
        nvec++;
        nfail++;
        $display("FAIL tmo_pulse: got 2-cycle pulse expected 1");
      end
    end
    stall_prev = !reset && cfg_valid_o && !cfg_ready_i;
    data_prev  = cfg_data_o;
    grant_prev = reset ? 3'b000 : grant_o;
    tmo_prev   = !reset && timeout_o;
  end

  task automatic do_reset();
    reset       = 1'b1;
    req_i       = '0;
    valid_i     = '0;
    last_i      = '0;
    data_i      = '0;
    cfg_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Returns at posedge+1 once grant_o is (non)zero.
  task automatic wait_grant(input bit nonzero, input string name);
    int n;
    n = 0;
    while (((grant_o !== 3'b000) != nonzero) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      nvec++;
      nfail++;
      $display("FAIL %s: grant_o=%03b, wait expired", name, grant_o);
    end
  endtask

  // Offer one beat; returns at posedge+1 after the accepting edge.
  task automatic send_beat(input int src, input logic [7:0] d,
                           input logic l, input bit push);
    int n;
    bit done;
    valid_i[src]        = 1'b1;
    data_i[src*8 +: 8]  = d;
    last_i[src]         = l;
    if (push) exp_q.push_back(d);
    n    = 0;
    done = 1'b0;
    while (!done && n < 100) begin
      @(negedge clk);
      done = ready_o[src];
      @(posedge clk);
      #1;
      n++;
    end
    valid_i[src] = 1'b0;
    last_i[src]  = 1'b0;
    if (!done) begin
      nvec++;
      nfail++;
      $display("FAIL send_beat: src %0d beat %02h not accepted", src, d);
    end
  endtask

  initial begin
    int order[4];
    int n;
    order = '{0, 1, 2, 0};

    // Reset state
    fork
      do_reset();
      begin
        @(negedge clk);
        chk("rst_grant", grant_o, 0);
        chk("rst_valid", cfg_valid_o, 0);
      end
    join
    @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_tmo", timeout_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_data", cfg_data_o, 0);
    @(posedge clk);
    #1;

    // Single USB transfer, A1..A4
    req_i = 3'b010;
    gexp_q.push_back(3'b010);
    @(negedge clk);
    chk("grant_lat0", grant_o, 3'b000);
    @(negedge clk);
    chk("grant_lat1", grant_o, 3'b010);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      send_beat(1, 8'(8'hA1 + i), (i == 3), 1'b1);
    end
    req_i = 3'b000;
    wait_grant(1'b0, "t1_release");
    @(negedge clk);
    chk("t1_busy", busy_o, 0);
    chk("t1_tmo_cnt", tmo_cnt, 0);
    @(posedge clk);
    #1;

    // Round-robin, all requesting
    do_reset();
    gexp_q.push_back(3'b001);
    gexp_q.push_back(3'b010);
    gexp_q.push_back(3'b100);
    gexp_q.push_back(3'b001);
    req_i = 3'b111;
    for (int i = 0; i < 4; i++) begin
      wait_grant(1'b1, "rr_grant");
      send_beat(order[i], 8'(8'hB0 + i), 1'b1, 1'b1);
      if (i == 3) req_i = 3'b000;
      wait_grant(1'b0, "rr_release");
    end

    // Back-pressure on a 6-beat USB transfer
    req_i = 3'b010;
    gexp_q.push_back(3'b010);
    wait_grant(1'b1, "bp_grant");
    bp_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send_beat(1, 8'(8'hC1 + i), (i == 5), 1'b1);
        end
        bp_en = 1'b0;
      end
      begin
        while (bp_en) begin
          @(posedge clk);
          #1;
          cfg_ready_i = ~cfg_ready_i;
        end
      end
    join
    cfg_ready_i = 1'b1;
    req_i = 3'b000;
    wait_grant(1'b0, "bp_release");

    // Idle timeout: src 0 stalls, src 2 waits
    do_reset();
    gexp_q.push_back(3'b001);
    gexp_q.push_back(3'b100);
    req_i = 3'b101;
    wait_grant(1'b1, "tmo_grant");
    send_beat(0, 8'hD1, 1'b0, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!timeout_o && n < 40);
    chk("tmo_latency", n, 17);
    chk("tmo_grant_held", grant_o, 3'b001);
    @(negedge clk);
    chk("tmo_pulse_end", timeout_o, 0);
    chk("tmo_released", grant_o, 3'b000);
    @(posedge clk);
    #1;
    wait_grant(1'b1, "tmo_next");
    send_beat(2, 8'hE1, 1'b1, 1'b1);
    req_i = 3'b000;
    wait_grant(1'b0, "tmo_next_release");
    chk("tmo_cnt", tmo_cnt, 1);

    // Source 2 drops request with a beat stuck in the buffer
    req_i = 3'b100;
    gexp_q.push_back(3'b100);
    wait_grant(1'b1, "drop_grant");
    send_beat(2, 8'hF1, 1'b0, 1'b1);
    send_beat(2, 8'hF2, 1'b0, 1'b1);
    cfg_ready_i = 1'b0;
    req_i = 3'b000;
    repeat (3) @(negedge clk);
    chk("drain_grant", grant_o, 3'b100);
    chk("drain_busy", busy_o, 1);
    chk("drain_valid", cfg_valid_o, 1);
    chk("drain_data", cfg_data_o, 8'hF2);
    @(posedge clk);
    #1 cfg_ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("drain_done_grant", grant_o, 3'b000);
    chk("drain_done_busy", busy_o, 0);
    chk("drain_done_valid", cfg_valid_o, 0);
    @(posedge clk);
    #1;

    // Async reset mid-transfer, buffer full
    req_i = 3'b010;
    gexp_q.push_back(3'b010);
    wait_grant(1'b1, "ar_grant");
    cfg_ready_i = 1'b0;
    send_beat(1, 8'h5A, 1'b0, 1'b0);
    @(negedge clk);
    chk("ar_pre_valid", cfg_valid_o, 1);
    #2;
    reset   = 1'b1;
    req_i   = 3'b000;
    valid_i = 3'b000;
    #1;
    chk("ar_valid", cfg_valid_o, 0);
    chk("ar_grant0", grant_o, 3'b000);
    chk("ar_busy", busy_o, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    cfg_ready_i = 1'b1;
    req_i = 3'b111;
    gexp_q.push_back(3'b001);
    wait_grant(1'b1, "ar_rearb");
    send_beat(0, 8'h77, 1'b1, 1'b1);
    req_i = 3'b000;
    wait_grant(1'b0, "ar_release");

    repeat (3) @(negedge clk);
    chk("beats_left", exp_q.size(), 0);
    chk("grants_left", gexp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
